writeback_stage: RTL

Receiving end of the execution-unit result interface. It captures the flopped execution result, its valid and its destination register index, and buffers them in a small in-order FIFO. It then drains them into the register-file write port under a ready handshake. It raises a stall toward the pipeline when the buffer is full and drops writes to x0.

---
 rtl/writeback_stage.sv | 118 +++++++++++
 1 files changed

// File: rtl/writeback_stage.sv
// Write-back buffer: in-order FIFO from execution results to the register-file write port.
// Optional WB_FORWARD_EN adds a youngest-match forwarding lookup over the buffered entries.
module writeback_stage #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned DEPTH          = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      result_valid,
    input  logic [DATA_WIDTH-1:0]     execution_result,
    input  logic [REG_ADDR_WIDTH-1:0] result_rd,
    output logic                      wb_stall,
    output logic                      wb_overflow,
    output logic                      rf_wr_en,
    output logic [REG_ADDR_WIDTH-1:0] rf_wr_addr,
    output logic [DATA_WIDTH-1:0]     rf_wr_data,
    input  logic                      rf_wr_ready,
`ifdef WB_FORWARD_EN
    input  logic [REG_ADDR_WIDTH-1:0] fwd_rd,
    output logic                      fwd_hit,
    output logic [DATA_WIDTH-1:0]     fwd_data,
`endif
    output logic [$clog2(DEPTH):0]    pending_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [REG_ADDR_WIDTH-1:0] rd_mem_q   [DEPTH];
    logic [DATA_WIDTH-1:0]     data_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    logic full;
    logic empty;
    logic nonzero_rd;
    logic push;
    logic pop;

    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);
    assign nonzero_rd = (result_rd != '0);
    // Fullness comes from registered count, so a same-cycle pop never frees room for a push.
    assign push       = result_valid && nonzero_rd && !full;
    assign pop        = !empty && rf_wr_ready;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (result_valid && nonzero_rd && full) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push) begin
            rd_mem_q[wr_ptr_q]   <= result_rd;
            data_mem_q[wr_ptr_q] <= execution_result;
        end
    end

    assign wb_stall      = full;
    assign wb_overflow   = overflow_q;
    assign pending_count = count_q;
    assign rf_wr_en      = !empty;
    assign rf_wr_addr    = empty ? '0 : rd_mem_q[rd_ptr_q];
    assign rf_wr_data    = empty ? '0 : data_mem_q[rd_ptr_q];

`ifdef WB_FORWARD_EN
    logic [PTR_W-1:0] fwd_idx;

    // Walk oldest to youngest so the last match seen is the most recent push.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (fwd_rd != '0) && (rd_mem_q[fwd_idx] == fwd_rd)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem_q[fwd_idx];
            end
        end
    end
`endif

endmodule
